// File: rtl/cell_comm_pkg.sv
// Shared definitions for the BPM fast-acquisition RX packet parser.
// Holds the header layout (marker value and field offsets), the packet
// length and the parser state enumeration.
package cell_comm_pkg;

   localparam logic [7:0] HDR_MARKER = 8'hA5;
   localparam int         CLIP_LSB   = 16;
   localparam int         MARKER_LSB = 24;
   localparam int         PKT_WORDS  = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GET_X     = 3'd1,
      ST_GET_Y     = 3'd2,
      ST_GET_S     = 3'd3,
      ST_AWAIT_CRC = 3'd4,
      ST_DISCARD   = 3'd5
   } rx_state_e;

endpackage

// File: rtl/cell_comm_bpm_rx_if.sv
// Bundle between the Aurora RX side and the BPM packet parser.
//   RX stream : channelUp, axisRxTvalid, axisRxTlast, axisRxTdata,
//               axisRxCRCvalid, axisRxCRCpass (no tready, always accepted)
//   Record    : recStrobe, recIndex, recClipped, recX, recY, recS
//   Counters  : goodCount, crcFaultCount, framingErrCount
// master = Aurora/test side, slave = parser.
interface cell_comm_bpm_rx_if #(
   parameter int ADC_COUNT      = 4,
   parameter int FOFB_IDX_WIDTH = 9,
   parameter int DATA_WIDTH     = 32
);
   logic                      channelUp;
   logic                      axisRxTvalid;
   logic                      axisRxTlast;
   logic [31:0]               axisRxTdata;
   logic                      axisRxCRCvalid;
   logic                      axisRxCRCpass;

   logic                      recStrobe;
   logic [FOFB_IDX_WIDTH-1:0] recIndex;
   logic [ADC_COUNT-1:0]      recClipped;
   logic [DATA_WIDTH-1:0]     recX;
   logic [DATA_WIDTH-1:0]     recY;
   logic [DATA_WIDTH-1:0]     recS;
   logic [31:0]               goodCount;
   logic [31:0]               crcFaultCount;
   logic [31:0]               framingErrCount;

   modport master (
      output channelUp, axisRxTvalid, axisRxTlast, axisRxTdata,
             axisRxCRCvalid, axisRxCRCpass,
      input  recStrobe, recIndex, recClipped, recX, recY, recS,
             goodCount, crcFaultCount, framingErrCount
   );

   modport slave (
      input  channelUp, axisRxTvalid, axisRxTlast, axisRxTdata,
             axisRxCRCvalid, axisRxCRCpass,
      output recStrobe, recIndex, recClipped, recX, recY, recS,
             goodCount, crcFaultCount, framingErrCount
   );
endinterface

// File: rtl/cell_comm_rx_counter.sv
// 32-bit wrapping event counter.
//   clk    : clock
//   rst    : asynchronous active-high reset, clears the count
//   inc_i  : count one event this cycle
//   count_o: current count, wraps 32'hFFFFFFFF -> 0
module cell_comm_rx_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [31:0] count_o
);
   logic [31:0] count_d;
   logic [31:0] count_q;

   always_comb begin
      count_d = count_q;
      if (inc_i) count_d = count_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/cell_comm_bpm_rx.sv
// Receive-side parser for BPM fast-acquisition packets on one Aurora ring
// direction. Checks framing (header marker, tlast only on the 4th word) and
// the Aurora CRC result, then presents one registered record per good
// packet and counts good packets, CRC faults and framing errors.
//   axisUserClk   : Aurora user clock
//   axisUserReset : asynchronous active-high reset
//   rx_if         : RX stream in, record and counters out (slave modport)
//
// state        | meaning
// ST_IDLE      | waiting for a header word
// ST_GET_X     | header taken, expecting X
// ST_GET_Y     | expecting Y
// ST_GET_S     | expecting S, which must carry tlast
// ST_AWAIT_CRC | packet complete, waiting up to CRC_TIMEOUT cycles for crcValid
// ST_DISCARD   | dropping words of a bad packet up to its tlast
module cell_comm_bpm_rx
   import cell_comm_pkg::*;
#(
   parameter int ADC_COUNT      = 4,
   parameter int FOFB_IDX_WIDTH = 9,
   parameter int DATA_WIDTH     = 32,
   parameter int CRC_TIMEOUT    = 15
) (
   input logic               axisUserClk,
   input logic               axisUserReset,
   cell_comm_bpm_rx_if.slave rx_if
);
   localparam int TMR_W = $clog2(CRC_TIMEOUT + 1);

   rx_state_e                 state_d, state_q;
   logic [TMR_W-1:0]          tmr_d, tmr_q;
   logic [FOFB_IDX_WIDTH-1:0] idx_d, idx_q;
   logic [ADC_COUNT-1:0]      clip_d, clip_q;
   logic [DATA_WIDTH-1:0]     x_d, x_q, y_d, y_q, s_d, s_q;
   logic                      commit_d, commit_q;

   logic                      rec_strobe_d, rec_strobe_q;
   logic [FOFB_IDX_WIDTH-1:0] rec_index_d, rec_index_q;
   logic [ADC_COUNT-1:0]      rec_clipped_d, rec_clipped_q;
   logic [DATA_WIDTH-1:0]     rec_x_d, rec_x_q, rec_y_d, rec_y_q, rec_s_d, rec_s_q;

   logic                      take_hdr;
   logic                      hdr_ok;
   logic                      good_inc, crc_fault_inc, framing_inc;

   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      idx_d         = idx_q;
      clip_d        = clip_q;
      x_d           = x_q;
      y_d           = y_q;
      s_d           = s_q;
      commit_d      = 1'b0;
      take_hdr      = 1'b0;
      crc_fault_inc = 1'b0;
      framing_inc   = 1'b0;
      hdr_ok        = (rx_if.axisRxTdata[MARKER_LSB +: 8] == HDR_MARKER);

      // A CRC-accepted packet becomes visible one cycle after acceptance;
      // the latched fields are copied before a following header can land.
      good_inc      = commit_q;
      rec_strobe_d  = commit_q;
      rec_index_d   = rec_index_q;
      rec_clipped_d = rec_clipped_q;
      rec_x_d       = rec_x_q;
      rec_y_d       = rec_y_q;
      rec_s_d       = rec_s_q;
      if (commit_q) begin
         rec_index_d   = idx_q;
         rec_clipped_d = clip_q;
         rec_x_d       = x_q;
         rec_y_d       = y_q;
         rec_s_d       = s_q;
      end

      if (!rx_if.channelUp) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_if.axisRxTvalid) take_hdr = 1'b1;
            end
            ST_GET_X: begin
               if (rx_if.axisRxTvalid) begin
                  if (rx_if.axisRxTlast) begin
                     framing_inc = 1'b1;
                     state_d     = ST_IDLE;
                  end else begin
                     x_d     = rx_if.axisRxTdata;
                     state_d = ST_GET_Y;
                  end
               end
            end
            ST_GET_Y: begin
               if (rx_if.axisRxTvalid) begin
                  if (rx_if.axisRxTlast) begin
                     framing_inc = 1'b1;
                     state_d     = ST_IDLE;
                  end else begin
                     y_d     = rx_if.axisRxTdata;
                     state_d = ST_GET_S;
                  end
               end
            end
            ST_GET_S: begin
               if (rx_if.axisRxTvalid) begin
                  s_d = rx_if.axisRxTdata;
                  if (!rx_if.axisRxTlast) begin
                     framing_inc = 1'b1;
                     state_d     = ST_DISCARD;
                  end else if (rx_if.axisRxCRCvalid) begin
                     state_d = ST_IDLE;
                     if (rx_if.axisRxCRCpass) commit_d      = 1'b1;
                     else                     crc_fault_inc = 1'b1;
                  end else begin
                     state_d = ST_AWAIT_CRC;
                     tmr_d   = TMR_W'(CRC_TIMEOUT - 1);
                  end
               end
            end
            ST_AWAIT_CRC: begin
               // A new word means the CRC for the pending packet never came;
               // that word is then treated as a fresh header.
               if (rx_if.axisRxTvalid) begin
                  crc_fault_inc = 1'b1;
                  take_hdr      = 1'b1;
               end else if (rx_if.axisRxCRCvalid) begin
                  state_d = ST_IDLE;
                  if (rx_if.axisRxCRCpass) commit_d      = 1'b1;
                  else                     crc_fault_inc = 1'b1;
               end else if (tmr_q == '0) begin
                  crc_fault_inc = 1'b1;
                  state_d       = ST_IDLE;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            ST_DISCARD: begin
               if (rx_if.axisRxTvalid && rx_if.axisRxTlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         if (take_hdr) begin
            if (hdr_ok && !rx_if.axisRxTlast) begin
               idx_d   = rx_if.axisRxTdata[FOFB_IDX_WIDTH-1:0];
               clip_d  = rx_if.axisRxTdata[CLIP_LSB +: ADC_COUNT];
               state_d = ST_GET_X;
            end else begin
               framing_inc = 1'b1;
               state_d     = rx_if.axisRxTlast ? ST_IDLE : ST_DISCARD;
            end
         end
      end
   end

   always_ff @(posedge axisUserClk or posedge axisUserReset) begin
      if (axisUserReset) begin
         state_q       <= ST_IDLE;
         tmr_q         <= '0;
         idx_q         <= '0;
         clip_q        <= '0;
         x_q           <= '0;
         y_q           <= '0;
         s_q           <= '0;
         commit_q      <= 1'b0;
         rec_strobe_q  <= 1'b0;
         rec_index_q   <= '0;
         rec_clipped_q <= '0;
         rec_x_q       <= '0;
         rec_y_q       <= '0;
         rec_s_q       <= '0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         idx_q         <= idx_d;
         clip_q        <= clip_d;
         x_q           <= x_d;
         y_q           <= y_d;
         s_q           <= s_d;
         commit_q      <= commit_d;
         rec_strobe_q  <= rec_strobe_d;
         rec_index_q   <= rec_index_d;
         rec_clipped_q <= rec_clipped_d;
         rec_x_q       <= rec_x_d;
         rec_y_q       <= rec_y_d;
         rec_s_q       <= rec_s_d;
      end
   end

   assign rx_if.recStrobe  = rec_strobe_q;
   assign rx_if.recIndex   = rec_index_q;
   assign rx_if.recClipped = rec_clipped_q;
   assign rx_if.recX       = rec_x_q;
   assign rx_if.recY       = rec_y_q;
   assign rx_if.recS       = rec_s_q;

   cell_comm_rx_counter u_good_cnt (
      .clk     (axisUserClk),
      .rst     (axisUserReset),
      .inc_i   (good_inc),
      .count_o (rx_if.goodCount)
   );

   cell_comm_rx_counter u_crc_cnt (
      .clk     (axisUserClk),
      .rst     (axisUserReset),
      .inc_i   (crc_fault_inc),
      .count_o (rx_if.crcFaultCount)
   );

   cell_comm_rx_counter u_frm_cnt (
      .clk     (axisUserClk),
      .rst     (axisUserReset),
      .inc_i   (framing_inc),
      .count_o (rx_if.framingErrCount)
   );
endmodule
